sipo_rx: RTL
============

# sipo_rx

Serial-in parallel-out UART receiver: the receive end of the 11-bit frame driven by the `piso` transmitter (start, D0..D7 LSB first, parity, stop). It oversamples the serial line, detects the start bit, samples each bit at mid-period and reassembles the data byte. It checks parity and stop, then reports the byte with a one-cycle done strobe. It sits between the line input pad and the receive-side consumer in the UART top.

## Interface
- `OVERSAMPLE`, 16: `clk` cycles per bit period; even, >= 4.
- `clk`  in  1  receive clock, running at OVERSAMPLE × baud rate.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  1  serial line; idle high.
- `parity_type`  in  2  parity mode: 2'b01 odd, 2'b10 even, 2'b00/2'b11 none (parity slot received but not checked); sampled at start-bit confirmation, held for the frame.
- `data_out`  out  8  last received byte.
- `rx_active`  out  1  high while a frame is in progress.
- `rx_done`  out  1  one-cycle pulse: frame complete, `data_out`/error flags valid.
- `parity_error`  out  1  parity mismatch on last frame.
- `stop_error`  out  1  stop bit sampled low on last frame.

## Operation
- `data_in` passes through a 2-flop synchronizer; both flops reset to 1. All logic below uses the synchronized line `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: wait for `rx_s` == 0. Clear the tick counter and go to START.
- START: count to OVERSAMPLE/2 − 1 (mid-bit), then sample.
  - `rx_s` == 1: false start; return to IDLE with no `rx_done` and no flag change.
  - `rx_s` == 0: latch `parity_type`, clear the bit index, go to DATA.
- DATA: sample every OVERSAMPLE cycles and shift into a byte register, LSB first. After 8 samples go to PARITY.
- PARITY: sample the parity bit.
  - Odd mode: error if XOR(D7..D0, p) == 0.
  - Even mode: error if XOR(D7..D0, p) == 1.
  - None: no error.
  - Go to STOP.
- STOP: sample the stop bit; error if 0. Then in the same cycle:
  - load `data_out` from the shift register;
  - update `parity_error` and `stop_error`;
  - pulse `rx_done`;
  - go to IDLE.
- The byte is delivered even when errors are flagged. Flags and `data_out` hold until the next `rx_done`.
- `rx_active` is 1 in START, DATA, PARITY and STOP; it deasserts in the cycle `rx_done` is high.
- The tick counter is $clog2(OVERSAMPLE) bits wide and wraps to 0 at each sample. The bit index is 3 bits.

## Timing
- Reset values: `data_out` = 8'h00, all 1-bit outputs 0, FSM in IDLE. Reset asserted mid-frame aborts the frame immediately: no `rx_done`, and flags are cleared.
- Start detection latency: 2 cycles (synchronizer) from the `data_in` falling edge to leaving IDLE.
- Sample points, measured from leaving IDLE:
  - start at OVERSAMPLE/2 cycles;
  - bit k (k = 0..7) at OVERSAMPLE/2 + (k+1)·OVERSAMPLE;
  - parity at +9·OVERSAMPLE;
  - stop at +10·OVERSAMPLE.
- `rx_done` is registered: high the cycle after the stop sample, for exactly 1 cycle.
- Back-to-back frames: IDLE is re-entered right after the stop sample, so a start edge arriving ≥ 1 cycle after mid-stop is captured. There is no dead time beyond the half stop bit.
- A line held low (break): start confirmed, data all 0, stop_error = 1. The receiver then waits in IDLE for the line to go high. It does not re-trigger until a new falling edge of `rx_s`, so IDLE must see `rx_s` == 1 before arming.
- A change of `parity_type` mid-frame has no effect on the current frame.

## Test plan
- Reset: `rst` high for 100 ns, 20 ns clk, `data_in` = 1 → all outputs 0, `rx_active` 0; release → still idle.
- Even parity, byte 8'hA5 (parity bit 0, stop 1) at 320 ns/bit → one `rx_done` pulse; `data_out` = 8'hA5, both errors 0; `rx_active` high ~3360 ns.
- Odd parity, byte 8'h3C with wrong parity bit 0 → `data_out` = 8'h3C, `parity_error` 1, `stop_error` 0; next good frame clears `parity_error`.
- Stop bit forced 0, parity none, byte 8'hFF → `stop_error` 1, `data_out` = 8'hFF; a held-low line afterwards produces no second frame until the line returns high and falls again.
- Glitch: `data_in` low for 100 ns (< half bit) → no `rx_done`, `rx_active` drops after mid-start, outputs unchanged.
- 10 back-to-back random frames with random `parity_type`, each checked against a scoreboard; plus `rst` pulsed mid-DATA → no `rx_done`, outputs 0, the following frame received correctly.

Source files
------------

// File: rtl/sipo_rx_if.sv
// Signal bundle between the serial line side and the UART receiver.
// The receiver takes the slave modport; the line driver / consumer side takes master.
interface sipo_rx_if;
   logic       data_in;
   logic [1:0] parity_type;
   logic [7:0] data_out;
   logic       rx_active;
   logic       rx_done;
   logic       parity_error;
   logic       stop_error;

   modport master (
      output data_in, parity_type,
      input  data_out, rx_active, rx_done, parity_error, stop_error
   );

   modport slave (
      input  data_in, parity_type,
      output data_out, rx_active, rx_done, parity_error, stop_error
   );
endinterface

// File: rtl/sipo_rx.sv
// Oversampling UART receiver for the 11-bit piso frame (start, D0..D7, parity, stop).
// Samples each bit at mid-period, checks parity/stop and strobes rx_done for one cycle.
module sipo_rx #(
   parameter int OVERSAMPLE = 16
) (
   input logic      clk,
   input logic      rst,
   sipo_rx_if.slave bus
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state, state_next;
   logic          rx_meta, rx_s;
   logic [TW-1:0] tick;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic [1:0]    par_mode;
   logic          par_err_pend;
   logic          armed;
   logic          sample;
   logic [7:0]    data_q;
   logic          done_q, perr_q, serr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.data_in;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // armed blocks re-triggering on a line still low after a break frame
   always_comb begin
      state_next = state;
      sample     = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s && armed) state_next = START;
         end
         START: begin
            if (tick == HALF_LAST) begin
               sample     = 1'b1;
               state_next = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick == FULL_LAST) begin
               sample = 1'b1;
               if (bit_idx == 3'd7) state_next = PARITY;
            end
         end
         PARITY: begin
            if (tick == FULL_LAST) begin
               sample     = 1'b1;
               state_next = STOP;
            end
         end
         STOP: begin
            if (tick == FULL_LAST) begin
               sample     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick         <= '0;
         bit_idx      <= 3'd0;
         shift_reg    <= 8'h00;
         par_mode     <= 2'b00;
         par_err_pend <= 1'b0;
         armed        <= 1'b1;
         data_q       <= 8'h00;
         done_q       <= 1'b0;
         perr_q       <= 1'b0;
         serr_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state == IDLE) tick <= '0;
         else               tick <= sample ? '0 : tick + 1'b1;

         case (state)
            IDLE: begin
               if (rx_s) armed <= 1'b1;
            end
            START: begin
               if (sample && !rx_s) begin
                  par_mode <= bus.parity_type;
                  bit_idx  <= 3'd0;
               end
            end
            DATA: begin
               if (sample) begin
                  shift_reg <= {rx_s, shift_reg[7:1]};
                  bit_idx   <= bit_idx + 3'd1;
               end
            end
            PARITY: begin
               if (sample) begin
                  case (par_mode)
                     2'b01:   par_err_pend <= ~(^{shift_reg, rx_s});
                     2'b10:   par_err_pend <= ^{shift_reg, rx_s};
                     default: par_err_pend <= 1'b0;
                  endcase
               end
            end
            STOP: begin
               if (sample) begin
                  data_q <= shift_reg;
                  perr_q <= par_err_pend;
                  serr_q <= ~rx_s;
                  done_q <= 1'b1;
                  armed  <= rx_s;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.data_out     = data_q;
   assign bus.rx_done      = done_q;
   assign bus.parity_error = perr_q;
   assign bus.stop_error   = serr_q;
   assign bus.rx_active    = (state != IDLE);
endmodule
